// File: rtl/conv_layer_calc_pkg.sv
// Shared helpers for the convolution dot-product block: kernel legality,
// accumulator extension bits per kernel size, and accumulator width.
package conv_layer_calc_pkg;

  function automatic bit kernel_legal(input int kernel);
    return (kernel == 1) || (kernel == 3) || (kernel == 5) || (kernel == 7);
  endfunction

  // Extension bits large enough that the worst-case tap sum cannot overflow.
  function automatic int ext_bits(input int kernel);
    case (kernel)
      1:       return 0;
      3:       return 3;
      5:       return 4;
      7:       return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int acc_width(input int n, input int m, input int e);
    return n + m + e;
  endfunction

endpackage

// File: rtl/carry_save_adder.sv
// Combinational 3:2 carry-save reduction of OPS operands into a sum vector
// and an already-shifted carry vector whose modular sum is the operand total.
module carry_save_adder
  import conv_layer_calc_pkg::*;
#(
  parameter int OPS   = 9,
  parameter int E     = 3,
  parameter int WIDTH = 7
) (
  input  logic [OPS*WIDTH-1:0] operands,
  output logic [WIDTH-1:0]     sum,
  output logic [WIDTH-1:0]     carry
);

  if (WIDTH <= E) begin : g_bad_width
    $error("carry_save_adder: WIDTH must exceed extension bits E");
  end

  if (OPS == 1) begin : g_one
    assign sum   = operands;
    assign carry = '0;
  end else if (OPS == 2) begin : g_two
    assign sum   = operands[0 +: WIDTH];
    assign carry = operands[WIDTH +: WIDTH];
  end else begin : g_tree
    logic [WIDTH-1:0] s_acc, c_acc, x_op, s_new;

    // Each stage folds one more operand into the running sum/carry pair.
    always_comb begin
      s_acc = operands[0 +: WIDTH];
      c_acc = operands[WIDTH +: WIDTH];
      x_op  = '0;
      s_new = '0;
      for (int i = 2; i < OPS; i++) begin
        x_op  = operands[i*WIDTH +: WIDTH];
        s_new = s_acc ^ c_acc ^ x_op;
        c_acc = ((s_acc & c_acc) | (s_acc & x_op) | (c_acc & x_op)) << 1;
        s_acc = s_new;
      end
    end

    assign sum   = s_acc;
    assign carry = c_acc;
  end

endmodule

// File: rtl/conv_layer_calc.sv
// Pipelined KERNEL x KERNEL signed dot product in redundant (sum/carry) form.
// Optional macro CONV_CALC_RESOLVE_EN adds a lookahead adder stage that resolves the result.
module conv_layer_calc
  import conv_layer_calc_pkg::*;
#(
  parameter int KERNEL = 3,
  parameter int E      = 3,
  parameter int N      = 2,
  parameter int M      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [KERNEL*KERNEL*N-1:0] data2conv,
  input  logic                       en_in,
  input  logic [KERNEL*KERNEL*M-1:0] w,
  output logic [N+M+E-1:0]           sum,
  output logic [N+M+E-1:0]           cout,
  output logic                       en_out
);

  localparam int TAPS = KERNEL * KERNEL;
  localparam int W    = acc_width(N, M, E);

  if (!kernel_legal(KERNEL)) begin : g_bad_kernel
    $error("conv_layer_calc: KERNEL must be 1, 3, 5 or 7");
  end
  if (E != ext_bits(KERNEL)) begin : g_bad_ext
    $error("conv_layer_calc: E does not match KERNEL");
  end

  logic [TAPS*W-1:0] prod_d, prod_q;
  logic              en_q1;
  logic [W-1:0]      csa_sum, csa_carry;
  logic [W-1:0]      sum_q2, carry_q2;
  logic              en_q2;

  // Operands are sign-extended to the full width before multiplying, so the
  // truncated product is already the sign-extended tap product.
  for (genvar j = 0; j < TAPS; j++) begin : g_tap
    logic signed [W-1:0] d_ext, w_ext;
    assign d_ext = W'($signed(data2conv[j*N +: N]));
    assign w_ext = W'($signed(w[j*M +: M]));
    assign prod_d[j*W +: W] = d_ext * w_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      en_q1  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      en_q1  <= en_in;
    end
  end

  carry_save_adder #(
    .OPS   (TAPS),
    .E     (E),
    .WIDTH (W)
  ) u_csa (
    .operands (prod_q),
    .sum      (csa_sum),
    .carry    (csa_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q2   <= '0;
      carry_q2 <= '0;
      en_q2    <= 1'b0;
    end else begin
      sum_q2   <= csa_sum;
      carry_q2 <= csa_carry;
      en_q2    <= en_q1;
    end
  end

`ifdef CONV_CALC_RESOLVE_EN
  logic [W-1:0] gen_c, prop_c, carry_c, resolved;
  logic [W-1:0] res_q;
  logic         en_q3;

  // Generate/propagate lookahead over the redundant pair.
  always_comb begin
    gen_c      = sum_q2 & carry_q2;
    prop_c     = sum_q2 ^ carry_q2;
    carry_c    = '0;
    for (int i = 0; i < W - 1; i++) begin
      carry_c[i+1] = gen_c[i] | (prop_c[i] & carry_c[i]);
    end
    resolved = prop_c ^ carry_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      en_q3 <= 1'b0;
    end else begin
      res_q <= resolved;
      en_q3 <= en_q2;
    end
  end

  assign sum    = res_q;
  assign cout   = '0;
  assign en_out = en_q3;
`else
  assign sum    = sum_q2;
  assign cout   = carry_q2;
  assign en_out = en_q2;
`endif

endmodule

// File: tb/tb_conv_layer_calc.sv
// Self-checking bench for conv_layer_calc (KERNEL=3, N=2, M=2, E=3):
// vector table plus hand sequences, expectations queued per cycle and popped at output.
module tb_conv_layer_calc;

  localparam int KERNEL = 3;
  localparam int N      = 2;
  localparam int M      = 2;
  localparam int E      = 3;
  localparam int TAPS   = KERNEL * KERNEL;
  localparam int W      = N + M + E;
`ifdef CONV_CALC_RESOLVE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [TAPS*N-1:0]    data2conv = '0;
  logic                 en_in = 1'b0;
  logic [TAPS*M-1:0]    w = '0;
  logic [W-1:0]         sum;
  logic [W-1:0]         cout;
  logic                 en_out;

  int n_vectors     = 0;
  int n_miscompares = 0;

  typedef struct {
    logic         en;
    logic [W-1:0] value;
    logic         exact_zero;
    string        name;
  } exp_t;

  typedef struct {
    logic [TAPS*N-1:0] data;
    logic [TAPS*M-1:0] wt;
    logic              en;
    logic [W-1:0]      value;
    logic              exact_zero;
    string             name;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];

  conv_layer_calc #(
    .KERNEL (KERNEL),
    .E      (E),
    .N      (N),
    .M      (M)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data2conv (data2conv),
    .en_in     (en_in),
    .w         (w),
    .sum       (sum),
    .cout      (cout),
    .en_out    (en_out)
  );

  always #5 clk = ~clk;

  function automatic int model_dot(input logic [TAPS*N-1:0] d, input logic [TAPS*M-1:0] wt);
    int acc = 0;
    for (int j = 0; j < TAPS; j++) begin
      acc += int'($signed(d[j*N +: N])) * int'($signed(wt[j*M +: M]));
    end
    return acc;
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [W-1:0] resolved;
    resolved = sum + cout;
    n_vectors++;
    if (en_out !== e.en) begin
      n_miscompares++;
      $display("[TB] FAIL %s en_out: got %b, want %b", e.name, en_out, e.en);
    end
`ifdef CONV_CALC_RESOLVE_EN
    if (sum !== e.value || cout !== '0) begin
      n_miscompares++;
      $display("[TB] FAIL %s result: got sum=%0d cout=%0d, want sum=%0d cout=0",
               e.name, sum, cout, e.value);
    end
`else
    if (resolved !== e.value) begin
      n_miscompares++;
      $display("[TB] FAIL %s result: got (sum+cout)=%0d (sum=%0d cout=%0d), want %0d",
               e.name, resolved, sum, cout, e.value);
    end
`endif
    if (e.exact_zero && (sum !== '0 || cout !== '0)) begin
      n_miscompares++;
      $display("[TB] FAIL %s zero: got sum=%0d cout=%0d, want both 0", e.name, sum, cout);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [TAPS*N-1:0] d,
                               input logic [TAPS*M-1:0] wt, input logic en,
                               input logic [W-1:0] value, input logic ez, input string name);
    exp_t e;
    @(negedge clk);
    rst       = r;
    data2conv = d;
    w         = wt;
    en_in     = en;
    if (!r) exp_q.push_back('{en, value, ez, name});
    @(posedge clk);
    #1;
    if (r) begin
      checkOutput('{1'b0, '0, 1'b1, {name, "_reset"}});
      exp_q.delete();
      for (int i = 0; i < LAT - 1; i++) exp_q.push_back('{1'b0, '0, 1'b1, "post_reset"});
    end else if (exp_q.size() >= LAT) begin
      e = exp_q.pop_front();
      checkOutput(e);
    end
  endtask

  task automatic applyModel(input logic [TAPS*N-1:0] d, input logic [TAPS*M-1:0] wt,
                            input logic en, input string name);
    applyStimulus(1'b0, d, wt, en, W'(model_dot(d, wt)), (d == '0) || (wt == '0), name);
  endtask

  task automatic applyIdle(input int cycles, input string name);
    for (int i = 0; i < cycles; i++)
      applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, name);
  endtask

  initial begin
    logic [TAPS*N-1:0] cyc;
    logic [31:0]       rnd_d;
    logic [31:0]       rnd_w;
    logic [31:0]       rnd_e;

    for (int j = 0; j < TAPS; j++) begin
      case (j % 3)
        0:       cyc[j*N +: N] = 2'b01;
        1:       cyc[j*N +: N] = 2'b11;
        default: cyc[j*N +: N] = 2'b00;
      endcase
    end

    vecs[0] = '{{TAPS{2'b10}}, {TAPS{2'b10}}, 1'b1, 7'd36,  1'b0, "neg_x_neg"};
    vecs[1] = '{{TAPS{2'b01}}, {TAPS{2'b10}}, 1'b1, 7'd110, 1'b0, "pos_x_neg"};
    vecs[2] = '{cyc,           {TAPS{2'b01}}, 1'b1, 7'd0,   1'b0, "cycling"};
    vecs[3] = '{'0,            {TAPS{2'b10}}, 1'b1, 7'd0,   1'b1, "zero_data"};
    vecs[4] = '{{TAPS{2'b10}}, {TAPS{2'b01}}, 1'b0, 7'd110, 1'b0, "en_low_adv"};
    vecs[5] = '{{TAPS{2'b01}}, {TAPS{2'b01}}, 1'b1, 7'd9,   1'b0, "pos_x_pos"};

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, '0, '0, 1'b0, '0, 1'b1, "init");

    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, vecs[i].data, vecs[i].wt, vecs[i].en, vecs[i].value,
                    vecs[i].exact_zero, vecs[i].name);
    applyIdle(LAT, "drain_table");

    applyStimulus(1'b0, {TAPS{2'b10}}, {TAPS{2'b10}}, 1'b1, 7'd36, 1'b0, "pulse");
    applyIdle(4, "after_pulse");

    for (int i = 0; i < 5; i++) begin
      rnd_d = $urandom;
      rnd_w = $urandom;
      applyModel(rnd_d[TAPS*N-1:0], rnd_w[TAPS*M-1:0], 1'b1, "burst");
    end
    applyIdle(LAT, "drain_burst");

    applyStimulus(1'b0, {TAPS{2'b10}}, {TAPS{2'b10}}, 1'b1, 7'd36, 1'b0, "pre_reset");
    applyStimulus(1'b1, {TAPS{2'b10}}, {TAPS{2'b10}}, 1'b1, '0, 1'b1, "mid_stream");
    applyIdle(LAT + 2, "no_stale");

    for (int i = 0; i < 20; i++) begin
      rnd_d = $urandom;
      rnd_w = $urandom;
      rnd_e = $urandom;
      applyModel(rnd_d[TAPS*N-1:0], rnd_w[TAPS*M-1:0], rnd_e[0], "random");
    end
    applyIdle(LAT, "drain_random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
